bpsk_upsampler: RTL and testbench
=================================

BPSK_UPSAMPLER -- requirements
Module: bpsk_upsampler

Interface
REQ-001 SHALL have parameter SYMBOL_WIDTH, default 16, total bits of the output sample word.
REQ-002 SHALL have parameter SYMBOL_FRAC, default 14, fractional bits of the output sample word.
REQ-003 SHALL have parameter SPS, default 8, output samples per symbol (upsampling factor).
REQ-004 SHALL have parameter CLK_DIV, default 4, clk cycles per output sample.
REQ-005 SHALL have port clk, input, 1, clock; rising edge only.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port en, input, 1, global enable; low freezes all state.
REQ-008 SHALL have port i_bit, input, 1, data bit to be mapped.
REQ-009 SHALL have port i_valid, input, 1, i_bit is valid this cycle.
REQ-010 SHALL have port o_ready, output, 1, block can accept a bit this cycle.
REQ-011 SHALL have port o_sample, output, SYMBOL_WIDTH, signed sample for the downstream pulse-shaping filter.
REQ-012 SHALL have port o_new_sample, output, 1, one-cycle strobe marking an o_sample update.
REQ-013 SHALL have port o_busy, output, 1, high while in RUN.
REQ-014 SHALL have port o_underrun, output, 1, one-cycle pulse when a symbol slot finds no bit buffered.

Function
REQ-015 SHALL hold one-entry bit buffer (buf_bit, buf_full); transfer occurs on a cycle with en && i_valid && o_ready, setting buf_full next cycle.
REQ-016 SHALL drive o_ready = en && !buf_full && !rst, combinationally; no accept while full.
REQ-017 SHALL run tick counter 0..CLK_DIV-1 while en; tick = (counter == CLK_DIV-1); counter wraps to 0 on tick.
REQ-018 SHALL, on each tick, register new o_sample and pulse o_new_sample high for exactly the following cycle; o_new_sample low otherwise.
REQ-019 SHALL map bit 1 -> +1.0 = 2^SYMBOL_FRAC, bit 0 -> -1.0 = -(2^SYMBOL_FRAC) in two's complement, SYMBOL_WIDTH bits; zero-stuffed samples = 0.
REQ-020 SHALL implement FSM states IDLE and RUN, with phase counter 0..SPS-1.
REQ-021 IDLE: on tick with buf_full -> emit mapped buf_bit, clear buf_full, phase <= 1 (or 0 if SPS==1), go RUN; on tick with buffer empty -> emit 0, stay IDLE, no underrun.
REQ-022 RUN, phase != 0 at tick: emit 0, phase <= (phase+1) mod SPS.
REQ-023 RUN, phase == 0 at tick, buf_full: emit mapped bit, clear buf_full, phase <= 1 mod SPS.
REQ-024 RUN, phase == 0 at tick, buffer empty: emit 0, pulse o_underrun, go IDLE.
REQ-025 Accept and consume SHALL never coincide (guaranteed by REQ-016); buffer refills earliest one cycle after consumption.
REQ-026 SHALL, when en low, hold counter, phase, state, buffer, o_sample; o_new_sample and o_underrun low.
REQ-027 o_busy SHALL equal (state == RUN), registered.
REQ-028 Symbol latency: bit accepted at cycle N appears on o_sample no earlier than the first tick after cycle N+1; sustained input yields exactly one nonzero sample per SPS ticks.
REQ-029 SHALL require CLK_DIV >= 2, SPS >= 1, SYMBOL_FRAC <= SYMBOL_WIDTH-2; violation SHALL stop elaboration/simulation with an error.

Reset
REQ-030 rst high SHALL, on next clk edge: o_sample = 0, o_new_sample = 0, o_underrun = 0, o_busy = 0, state IDLE, phase 0, tick counter 0, buf_full 0.
REQ-031 rst mid-symbol SHALL discard buffered bit and current phase; no strobe on the reset cycle; first tick at the CLK_DIV-th enabled cycle after rst falls.
REQ-032 rst SHALL take priority over en and i_valid.

Verification (SPS=4, CLK_DIV=3, SYMBOL_WIDTH=16, SYMBOL_FRAC=14)
REQ-033 Reset then idle, i_valid=0 for 30 cycles -> o_new_sample every 3rd cycle, o_sample always 0x0000, o_busy 0, no underrun.
REQ-034 Stream bits 1,0,1 held valid continuously -> o_sample sequence 0x4000,0,0,0,0xC000,0,0,0,0x4000,0,0,0 on strobes; o_ready low while buffer full.
REQ-035 Single bit 1, then i_valid=0 -> 0x4000,0,0,0, then 0 with o_underrun pulse at 5th strobe, o_busy falls, IDLE.
REQ-036 en low for 7 cycles mid-symbol -> no strobes, o_sample/phase frozen; resume continues exact sequence with no sample lost or duplicated.
REQ-037 rst asserted at phase 2 with bit buffered -> all outputs 0 next cycle, buffered bit never emitted, first strobe 3 cycles after rst release, o_sample 0.
REQ-038 i_valid asserted on the same cycle a tick consumes the buffer -> bit not accepted that cycle (o_ready low), accepted next cycle, emitted at next phase-0 tick.

Source files
------------

// File: rtl/bpsk_upsampler.sv
// bpsk_upsampler: maps a serial bit stream onto +/-1.0 fixed-point BPSK symbols
// and zero-stuffs SPS-1 zero samples after each symbol. One output sample is
// produced every CLK_DIV enabled clock cycles and flagged by o_new_sample.
module bpsk_upsampler #(
  parameter int SYMBOL_WIDTH = 16,
  parameter int SYMBOL_FRAC  = 14,
  parameter int SPS          = 8,
  parameter int CLK_DIV      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           i_bit,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic signed [SYMBOL_WIDTH-1:0] o_sample,
  output logic                           o_new_sample,
  output logic                           o_busy,
  output logic                           o_underrun
);
  // state | meaning
  // IDLE  | no symbol in flight; ticks emit zeros until a bit is buffered
  // RUN   | inside a symbol period; phase counts samples 0..SPS-1, phase 0 is the symbol slot

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = (SPS > 1) ? $clog2(SPS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_MAX   = PH_W'((SPS > 1) ? SPS - 1 : 0);
  localparam logic [PH_W-1:0]  PH_FIRST = PH_W'((SPS > 1) ? 1 : 0);

  localparam logic signed [SYMBOL_WIDTH-1:0] SYM_POS = SYMBOL_WIDTH'(1) << SYMBOL_FRAC;
  localparam logic signed [SYMBOL_WIDTH-1:0] SYM_NEG = -SYM_POS;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Illegal parameter sets stop elaboration.
  if (CLK_DIV < 2) begin : g_chk_clk_div
    $error("bpsk_upsampler: CLK_DIV must be >= 2");
  end
  if (SPS < 1) begin : g_chk_sps
    $error("bpsk_upsampler: SPS must be >= 1");
  end
  if (SYMBOL_FRAC > SYMBOL_WIDTH - 2) begin : g_chk_frac
    $error("bpsk_upsampler: SYMBOL_FRAC must be <= SYMBOL_WIDTH-2");
  end

  logic [CNT_W-1:0]               cnt;
  logic [PH_W-1:0]                phase;
  logic [0:0]                     state;
  logic                           buf_bit;
  logic                           buf_full;
  logic                           tick;
  logic                           accept;
  logic                           consume;
  logic                           underrun;
  logic [0:0]                     nxt_state;
  logic [PH_W-1:0]                nxt_phase;
  logic signed [SYMBOL_WIDTH-1:0] nxt_sample;

  // A full buffer blocks acceptance, so accept and consume can never coincide.
  assign o_ready = en && !buf_full && !rst;
  assign accept  = i_valid && o_ready;
  assign tick    = en && (cnt == CNT_MAX);
  assign o_busy  = (state == ST_RUN);

  // Decide what the next tick emits and where the FSM goes.
  always_comb begin
    nxt_state  = state;
    nxt_phase  = phase;
    nxt_sample = '0;
    consume    = 1'b0;
    underrun   = 1'b0;
    if (state == ST_IDLE) begin
      if (buf_full) begin
        consume    = 1'b1;
        nxt_sample = buf_bit ? SYM_POS : SYM_NEG;
        nxt_phase  = PH_FIRST;
        nxt_state  = ST_RUN;
      end
    end else if (phase != '0) begin
      nxt_phase = (phase == PH_MAX) ? '0 : phase + 1'b1;
    end else if (buf_full) begin
      consume    = 1'b1;
      nxt_sample = buf_bit ? SYM_POS : SYM_NEG;
      nxt_phase  = PH_FIRST;
    end else begin
      underrun  = 1'b1;
      nxt_state = ST_IDLE;
    end
  end

  // One-entry bit buffer: filled on accept, emptied when a symbol slot takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_bit  <= 1'b0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_bit  <= i_bit;
    end else if (tick && consume) begin
      buf_full <= 1'b0;
    end
  end

  // Tick divider, FSM and registered sample outputs; all frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      phase        <= '0;
      state        <= ST_IDLE;
      o_sample     <= '0;
      o_new_sample <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      o_new_sample <= 1'b0;
      o_underrun   <= 1'b0;
      if (en) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          o_sample     <= nxt_sample;
          o_new_sample <= 1'b1;
          o_underrun   <= underrun;
          state        <= nxt_state;
          phase        <= nxt_phase;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_upsampler.sv
// Directed testbench for bpsk_upsampler with SPS=4, CLK_DIV=3, Q1.14 samples.
module tb_bpsk_upsampler;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                i_bit;
  logic                i_valid;
  logic                o_ready;
  logic signed [W-1:0] o_sample;
  logic                o_new_sample;
  logic                o_busy;
  logic                o_underrun;

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] q_samp[$];
  logic                q_und[$];
  bit                  bits[$];
  int                  bi;

  bpsk_upsampler #(
    .SYMBOL_WIDTH(16),
    .SYMBOL_FRAC (14),
    .SPS         (4),
    .CLK_DIV     (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .i_bit       (i_bit),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_sample    (o_sample),
    .o_new_sample(o_new_sample),
    .o_busy      (o_busy),
    .o_underrun  (o_underrun)
  );

  always #5 clk = ~clk;

  // Advance one clock and record any strobed sample, sampling 1 time unit after the edge.
  task automatic edge_sample();
    @(posedge clk);
    #1;
    if (o_new_sample === 1'b1) begin
      q_samp.push_back(o_sample);
      q_und.push_back(o_underrun);
    end
  endtask

  // Present the next queued bit (if any), advance one clock, report accept and ready.
  task automatic cyc(output logic acc, output logic rdy);
    if (bi < bits.size()) begin
      i_valid = 1'b1;
      i_bit   = bits[bi];
    end else begin
      i_valid = 1'b0;
    end
    #1;
    rdy = o_ready;
    acc = o_ready && i_valid;
    edge_sample();
    if (acc) bi++;
  endtask

  task automatic reset_dut();
    rst = 1'b1; en = 1'b1; i_valid = 1'b0; i_bit = 1'b0;
    edge_sample();
    edge_sample();
    rst = 1'b0;
    q_samp.delete();
    q_und.delete();
    bits.delete();
    bi = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; i_valid = 1'b1; i_bit = 1'b1;
    edge_sample();
    edge_sample();
    checks++;
    if (o_sample !== 16'sh0000 || o_new_sample !== 1'b0 || o_busy !== 1'b0 || o_underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got sample=%h new=%b busy=%b und=%b expected 0000 0 0 0",
               o_sample, o_new_sample, o_busy, o_underrun);
    end
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0", o_ready);
    end
    rst = 1'b0; i_valid = 1'b0;
    q_samp.delete();
    q_und.delete();
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", o_ready);
    end
    edge_sample();
    edge_sample();
    checks++;
    if (q_samp.size() != 0) begin
      errors++;
      $display("FAIL first_tick_early: got %0d strobes expected 0", q_samp.size());
    end
    edge_sample();
    checks++;
    if (q_samp.size() != 1 || o_new_sample !== 1'b1) begin
      errors++;
      $display("FAIL first_tick_time: got %0d strobes new=%b expected 1 1", q_samp.size(), o_new_sample);
    end
  endtask

  task automatic test_idle();
    int n_strobe;
    int misplaced;
    int nonzero;
    int bad_flags;
    reset_dut();
    n_strobe = 0; misplaced = 0; nonzero = 0; bad_flags = 0;
    for (int k = 1; k <= 30; k++) begin
      edge_sample();
      if (o_new_sample === 1'b1) begin
        n_strobe++;
        if (k % 3 != 0) misplaced++;
        if (o_sample !== 16'sh0000) nonzero++;
      end
      if (o_busy !== 1'b0 || o_underrun !== 1'b0) bad_flags++;
    end
    checks++;
    if (n_strobe != 10 || misplaced != 0) begin
      errors++;
      $display("FAIL idle_strobes: got %0d strobes, %0d misplaced expected 10, 0", n_strobe, misplaced);
    end
    checks++;
    if (nonzero != 0) begin
      errors++;
      $display("FAIL idle_samples: got %0d nonzero samples expected 0", nonzero);
    end
    checks++;
    if (bad_flags != 0) begin
      errors++;
      $display("FAIL idle_flags: got %0d cycles with busy/underrun expected 0", bad_flags);
    end
  endtask

  task automatic test_stream();
    logic signed [W-1:0] exp_s[12];
    logic signed [W-1:0] got;
    logic acc, rdy, full;
    int rdy_bad;
    int n_before;
    int und_cnt;
    exp_s = '{16'sh4000, 16'sh0000, 16'sh0000, 16'sh0000,
              16'shC000, 16'sh0000, 16'sh0000, 16'sh0000,
              16'sh4000, 16'sh0000, 16'sh0000, 16'sh0000};
    reset_dut();
    bits = '{1'b1, 1'b0, 1'b1};
    full = 1'b0; rdy_bad = 0;
    for (int k = 0; k < 36; k++) begin
      n_before = q_samp.size();
      cyc(acc, rdy);
      if (rdy !== !full) rdy_bad++;
      if (q_samp.size() > n_before && q_samp[q_samp.size()-1] !== 16'sh0000) full = 1'b0;
      if (acc) full = 1'b1;
    end
    for (int i = 0; i < 12; i++) begin
      got = (i < q_samp.size()) ? q_samp[i] : 'x;
      checks++;
      if (got !== exp_s[i]) begin
        errors++;
        $display("FAIL stream_sample[%0d]: got %h expected %h", i, got, exp_s[i]);
      end
    end
    checks++;
    if (q_samp.size() != 12) begin
      errors++;
      $display("FAIL stream_count: got %0d strobes expected 12", q_samp.size());
    end
    checks++;
    if (rdy_bad != 0 || bi != 3) begin
      errors++;
      $display("FAIL stream_ready: got %0d ready errors, %0d bits accepted expected 0, 3", rdy_bad, bi);
    end
    und_cnt = 0;
    foreach (q_und[i]) if (q_und[i] !== 1'b0) und_cnt++;
    checks++;
    if (und_cnt != 0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_flags: got underruns=%0d busy=%b expected 0 1", und_cnt, o_busy);
    end
  endtask

  task automatic test_single();
    logic signed [W-1:0] exp_s[5];
    logic                exp_u[5];
    logic signed [W-1:0] got;
    logic                got_u;
    logic acc, rdy;
    exp_s = '{16'sh4000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000};
    exp_u = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    reset_dut();
    bits = '{1'b1};
    for (int k = 1; k <= 15; k++) begin
      cyc(acc, rdy);
      if (k == 3) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL single_busy_rise: got %b expected 1", o_busy);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      got   = (i < q_samp.size()) ? q_samp[i] : 'x;
      got_u = (i < q_und.size()) ? q_und[i] : 1'bx;
      checks++;
      if (got !== exp_s[i] || got_u !== exp_u[i]) begin
        errors++;
        $display("FAIL single_strobe[%0d]: got %h und=%b expected %h und=%b", i, got, got_u, exp_s[i], exp_u[i]);
      end
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall: got %b expected 0", o_busy);
    end
    cyc(acc, rdy);
    checks++;
    if (o_underrun !== 1'b0 || o_new_sample !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width: got und=%b new=%b expected 0 0", o_underrun, o_new_sample);
    end
  endtask

  task automatic test_enable_freeze();
    logic signed [W-1:0] exp_s[8];
    logic signed [W-1:0] got;
    logic signed [W-1:0] frozen;
    logic acc, rdy;
    int rdy_seen;
    exp_s = '{16'sh4000, 16'sh0000, 16'sh0000, 16'sh0000,
              16'shC000, 16'sh0000, 16'sh0000, 16'sh0000};
    reset_dut();
    bits = '{1'b1, 1'b0};
    for (int k = 0; k < 7; k++) cyc(acc, rdy);
    frozen = o_sample;
    en = 1'b0;
    rdy_seen = 0;
    for (int k = 0; k < 7; k++) begin
      cyc(acc, rdy);
      if (rdy !== 1'b0) rdy_seen++;
    end
    checks++;
    if (q_samp.size() != 2 || o_sample !== frozen || o_busy !== 1'b1 || rdy_seen != 0) begin
      errors++;
      $display("FAIL freeze_hold: got strobes=%0d sample=%h busy=%b ready_cycles=%0d expected 2 %h 1 0",
               q_samp.size(), o_sample, o_busy, rdy_seen, frozen);
    end
    en = 1'b1;
    cyc(acc, rdy);
    checks++;
    if (o_new_sample !== 1'b0) begin
      errors++;
      $display("FAIL resume_early: got new=%b expected 0", o_new_sample);
    end
    cyc(acc, rdy);
    checks++;
    if (o_new_sample !== 1'b1) begin
      errors++;
      $display("FAIL resume_tick: got new=%b expected 1", o_new_sample);
    end
    for (int k = 0; k < 15; k++) cyc(acc, rdy);
    for (int i = 0; i < 8; i++) begin
      got = (i < q_samp.size()) ? q_samp[i] : 'x;
      checks++;
      if (got !== exp_s[i]) begin
        errors++;
        $display("FAIL freeze_sample[%0d]: got %h expected %h", i, got, exp_s[i]);
      end
    end
    checks++;
    if (q_samp.size() != 8) begin
      errors++;
      $display("FAIL freeze_count: got %0d strobes expected 8", q_samp.size());
    end
  endtask

  task automatic test_reset_mid();
    logic acc, rdy;
    int bad;
    reset_dut();
    bits = '{1'b1, 1'b1};
    for (int k = 0; k < 7; k++) cyc(acc, rdy);
    checks++;
    if (o_busy !== 1'b1 || bi != 2) begin
      errors++;
      $display("FAIL mid_setup: got busy=%b accepted=%0d expected 1 2", o_busy, bi);
    end
    rst = 1'b1; i_valid = 1'b1; i_bit = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_ready: got %b expected 0", o_ready);
    end
    edge_sample();
    checks++;
    if (o_sample !== 16'sh0000 || o_new_sample !== 1'b0 || o_busy !== 1'b0 || o_underrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_outputs: got sample=%h new=%b busy=%b und=%b expected 0000 0 0 0",
               o_sample, o_new_sample, o_busy, o_underrun);
    end
    rst = 1'b0; i_valid = 1'b0;
    q_samp.delete();
    q_und.delete();
    edge_sample();
    edge_sample();
    edge_sample();
    checks++;
    if (q_samp.size() != 1 || o_new_sample !== 1'b1 || o_sample !== 16'sh0000) begin
      errors++;
      $display("FAIL mid_first_strobe: got strobes=%0d new=%b sample=%h expected 1 1 0000",
               q_samp.size(), o_new_sample, o_sample);
    end
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      edge_sample();
      if (o_busy !== 1'b0) bad++;
    end
    foreach (q_samp[i]) if (q_samp[i] !== 16'sh0000) bad++;
    checks++;
    if (bad != 0 || q_samp.size() != 5) begin
      errors++;
      $display("FAIL mid_discard: got %0d bad cycles/samples, %0d strobes expected 0, 5", bad, q_samp.size());
    end
  endtask

  task automatic test_collide();
    logic signed [W-1:0] exp_s[5];
    logic signed [W-1:0] got;
    exp_s = '{16'sh4000, 16'sh0000, 16'sh0000, 16'sh0000, 16'shC000};
    reset_dut();
    i_valid = 1'b1; i_bit = 1'b1;
    edge_sample();
    i_valid = 1'b0;
    edge_sample();
    i_valid = 1'b1; i_bit = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_ready_low: got %b expected 0", o_ready);
    end
    edge_sample();
    checks++;
    if (o_ready !== 1'b1 || o_new_sample !== 1'b1) begin
      errors++;
      $display("FAIL collide_after_consume: got ready=%b new=%b expected 1 1", o_ready, o_new_sample);
    end
    edge_sample();
    i_valid = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_accepted: got ready=%b expected 0", o_ready);
    end
    for (int k = 0; k < 11; k++) edge_sample();
    for (int i = 0; i < 5; i++) begin
      got = (i < q_samp.size()) ? q_samp[i] : 'x;
      checks++;
      if (got !== exp_s[i]) begin
        errors++;
        $display("FAIL collide_sample[%0d]: got %h expected %h", i, got, exp_s[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; i_valid = 1'b0; i_bit = 1'b0; bi = 0;
    test_reset();
    test_idle();
    test_stream();
    test_single();
    test_enable_freeze();
    test_reset_mid();
    test_collide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
